rr_grant_arbiter8: RTL and testbench
====================================

// Module: rr_grant_arbiter8
// PURPOSE
//  Round-robin arbiter sharing one resource among 8 requesters. Selects one
//  winner, holds its grant until it releases or a hold limit expires, then
//  rotates priority. Grant_idx is the 3-bit encoded winner and Grant is its
//  one-hot 3-to-8 decode; downstream select logic consumes either form.
// PARAMETERS
//  MAX_HOLD  16  max consecutive granted cycles per owner; 0 = unlimited; legal 0..255
// PORTS
//  Clk        input   1  system clock, all state on rising edge
//  Rst_n      input   1  asynchronous active-low reset
//  Enable     input   1  1 = new grants may be issued; 0 = no new grants
//  Req        input   8  request per requester; held high while resource needed
//  Grant      output  8  one-hot grant, registered; 8'h00 when none
//  Grant_idx  output  3  encoded owner; valid only while Busy=1
//  Busy       output  1  1 while a grant is active (Grant != 0)
//  Timeout    output  1  1-cycle pulse: grant revoked by MAX_HOLD expiry
// BEHAVIOUR
//  - Clock Clk, reset Rst_n: one clock; reset is asynchronous and active-low.
//  - Reset (async, any state incl. mid-grant): Grant=8'h00, Grant_idx=0, Busy=0,
//    Timeout=0, priority pointer Ptr=0, hold count=0, state IDLE. Outputs
//    drop immediately on Rst_n falling, not at the next edge.
//  - All outputs registered; Grant is the decode of the registered Grant_idx
//    gated by Busy (no glitches from Req).
//  - States: IDLE -> GRANT -> GAP -> IDLE.
//  - IDLE: on an edge with Enable=1 and Req!=0, winner = first set Req bit
//    searching Ptr, Ptr+1, ..., 7, 0, ..., Ptr-1 (mod 8). Grant_idx<=winner,
//    Busy<=1, count<=1, state<=GRANT. Latency: Req high at edge N -> Grant
//    visible after edge N (1 cycle). Else remain IDLE, outputs 0.
//  - GRANT: evaluated each edge on current owner o=Grant_idx:
//    * Req[o]=0 -> release: Busy<=0, Grant<=0, Ptr<=o+1 mod 8 (7 wraps to 0),
//      state<=GAP, Timeout<=0.
//    * else MAX_HOLD!=0 and count==MAX_HOLD -> revoke: same as release plus
//      Timeout<=1 for exactly one cycle.
//    * else count<=count+1 (8-bit, saturates at 255 when MAX_HOLD=0), hold.
//    * Release and expiry on same edge (Req[o]=0, count==MAX_HOLD): release,
//      Timeout stays 0.
//    * Other requesters' Req and Enable ignored; Enable=0 does not revoke.
//  - GAP: exactly one cycle with Grant=0, Busy=0; state<=IDLE. No arbitration
//    in GAP, so back-to-back owners are separated by >=2 idle cycles
//    (GAP + IDLE arbitration cycle).
//  - Revoked owner keeping Req high is re-queued at lowest priority (Ptr past it);
//    sole requester is re-granted after GAP+IDLE.
//  - Grant always one-hot or zero; Busy == |Grant at all times.
// TESTING
//  1. Req=8'h01 granted, assert Rst_n=0 mid-grant -> Grant=0,Busy=0 same
//     cycle; release reset, Req=8'h08 -> Grant=8'h08, Grant_idx=3 one cycle later.
//  2. MAX_HOLD=4, Req=8'hFF constant -> owners 0,1,...,7,0 in order, each
//     Grant 4 cycles, Timeout pulse on each revoke, 2 zero cycles between.
//  3. Ptr=0, Req=8'b1000_0100 -> idx 2; Req[2] drops -> next idx 7; Req[2]
//     reasserted, Req[7] drops -> next idx 2 (wrap 7->0 verified).
//  4. MAX_HOLD=16, Req[5] high 3 cycles -> Grant=8'h20 for 3 cycles starting
//     1 cycle after Req rise, Timeout never asserts.
//  5. Enable=0, Req=8'h10 -> Grant=0 indefinitely; Enable=1 -> Grant=8'h10
//     next cycle; Enable=0 mid-grant -> grant held until Req[4] drops.
//  6. MAX_HOLD=3, Req[1] drops on the edge where count==3 -> Grant=0 next
//     cycle, Timeout=0; MAX_HOLD=0 with Req held 300 cycles -> no revoke.

Source files
------------

// File: rtl/rr_grant_arbiter8_if.sv
// Bus between the 8-way round-robin arbiter and its requesters.
//   Enable    : new grants may be issued when 1
//   Req[7:0]  : per-requester request, held while the resource is needed
//   Grant[7:0]: one-hot grant (0 when none)
//   Grant_idx : encoded owner, meaningful only while Busy=1
//   Busy      : a grant is active
//   Timeout   : 1-cycle pulse when a grant is revoked by the hold limit
// master = requester side, slave = arbiter side.
interface rr_grant_arbiter8_if;
  logic       Enable;
  logic [7:0] Req;
  logic [7:0] Grant;
  logic [2:0] Grant_idx;
  logic       Busy;
  logic       Timeout;

  modport master (output Enable, Req, input Grant, Grant_idx, Busy, Timeout);
  modport slave  (input Enable, Req, output Grant, Grant_idx, Busy, Timeout);
endinterface

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// A winner is picked in IDLE (search starts at the priority pointer), holds
// the grant until it drops its request or MAX_HOLD cycles elapse, then one
// GAP cycle is inserted before the next arbitration.
// Ports:
//   Clk   : clock, all state on the rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : slave side of rr_grant_arbiter8_if (Enable/Req in,
//           Grant/Grant_idx/Busy/Timeout out)
// MAX_HOLD: max consecutive grant cycles per owner, 0 = unlimited, 0..255.
module rr_grant_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                Clk,
  input  logic                Rst_n,
  rr_grant_arbiter8_if.slave  bus
);

  localparam int unsigned NUM_REQ  = 8;
  localparam logic [7:0]  HOLD_LIM = 8'(MAX_HOLD);
  localparam logic        HOLD_ON  = (MAX_HOLD != 0);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q,   ptr_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [2:0] idx_q,   idx_d;
  logic       busy_q,  busy_d;
  logic       tout_q,  tout_d;

  // Rotating priority search: first set Req bit at ptr, ptr+1, ... (mod 8).
  logic [2:0] win;
  logic       win_vld;
  logic [2:0] cand;

  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_vld && bus.Req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Enable && win_vld) begin
          idx_d   = win;
          busy_d  = 1'b1;
          cnt_d   = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Release wins over expiry on the same edge, so Timeout only fires
        // when the owner still wanted the resource.
        if (!bus.Req[idx_q] || (HOLD_ON && cnt_q == HOLD_LIM)) begin
          tout_d  = bus.Req[idx_q];
          busy_d  = 1'b0;
          idx_d   = '0;
          ptr_d   = idx_q + 3'd1;   // owner drops to lowest priority
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;       // saturates when unlimited
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
    end
  end

  // Decode purely from flops, so Req cannot glitch Grant.
  assign bus.Grant     = busy_q ? (8'b1 << idx_q) : 8'h00;
  assign bus.Grant_idx = idx_q;
  assign bus.Busy      = busy_q;
  assign bus.Timeout   = tout_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
module tb_rr_grant_arbiter8;

  localparam int NI = 4;
  localparam int HOLD [NI] = '{16, 4, 3, 0};

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;

  always #5 Clk = ~Clk;

  rr_grant_arbiter8_if if0 ();
  rr_grant_arbiter8_if if1 ();
  rr_grant_arbiter8_if if2 ();
  rr_grant_arbiter8_if if3 ();

  assign if0.Enable = en;  assign if0.Req = req;
  assign if1.Enable = en;  assign if1.Req = req;
  assign if2.Enable = en;  assign if2.Req = req;
  assign if3.Enable = en;  assign if3.Req = req;

  rr_grant_arbiter8 #(.MAX_HOLD(16)) u_h16 (.Clk(Clk), .Rst_n(Rst_n), .bus(if0));
  rr_grant_arbiter8 #(.MAX_HOLD(4))  u_h4  (.Clk(Clk), .Rst_n(Rst_n), .bus(if1));
  rr_grant_arbiter8 #(.MAX_HOLD(3))  u_h3  (.Clk(Clk), .Rst_n(Rst_n), .bus(if2));
  rr_grant_arbiter8 #(.MAX_HOLD(0))  u_h0  (.Clk(Clk), .Rst_n(Rst_n), .bus(if3));

  logic [7:0] o_g   [NI];
  logic [2:0] o_idx [NI];
  logic       o_b   [NI];
  logic       o_to  [NI];

  assign o_g[0] = if0.Grant; assign o_idx[0] = if0.Grant_idx; assign o_b[0] = if0.Busy; assign o_to[0] = if0.Timeout;
  assign o_g[1] = if1.Grant; assign o_idx[1] = if1.Grant_idx; assign o_b[1] = if1.Busy; assign o_to[1] = if1.Timeout;
  assign o_g[2] = if2.Grant; assign o_idx[2] = if2.Grant_idx; assign o_b[2] = if2.Busy; assign o_to[2] = if2.Timeout;
  assign o_g[3] = if3.Grant; assign o_idx[3] = if3.Grant_idx; assign o_b[3] = if3.Busy; assign o_to[3] = if3.Timeout;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(string nm, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: owner (-1 = none), one-cycle gap flag, hold count,
  // priority pointer and last-edge timeout, per instance.
  int m_own [NI];
  int m_gap [NI];
  int m_cnt [NI];
  int m_ptr [NI];
  int m_to  [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_own[k] = -1; m_gap[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      m_to[k] = 0;
      if (m_own[k] >= 0) begin
        bit still = req[m_own[k]];
        bit expire = (HOLD[k] != 0) && (m_cnt[k] == HOLD[k]);
        if (!still || expire) begin
          m_to[k]  = still ? 1 : 0;
          m_ptr[k] = (m_own[k] + 1) % 8;
          m_own[k] = -1;
          m_gap[k] = 1;
        end else if (m_cnt[k] < 255) begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end else if (m_gap[k] != 0) begin
        m_gap[k] = 0;
      end else if (en && req != 8'h00) begin
        for (int i = 0; i < 8; i++) begin
          int w = (m_ptr[k] + i) % 8;
          if (m_own[k] < 0 && req[w]) begin
            m_own[k] = w;
            m_cnt[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      int eg = (m_own[k] >= 0) ? (1 << m_own[k]) : 0;
      chk($sformatf("m%0d_grant", k), o_g[k], eg);
      chk($sformatf("m%0d_busy", k), o_b[k], (m_own[k] >= 0) ? 1 : 0);
      chk($sformatf("m%0d_timeout", k), o_to[k], m_to[k]);
      chk($sformatf("m%0d_busy_or", k), o_b[k], (o_g[k] != 8'h00) ? 1 : 0);
      if (m_own[k] >= 0) chk($sformatf("m%0d_idx", k), o_idx[k], m_own[k]);
    end
  endtask

  // Inputs are stable here; model evaluates the coming edge, then sample #1 after it.
  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    compare_all();
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks outputs drop at once.
  task automatic do_reset();
    #2 Rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst%0d_grant", k), o_g[k], 0);
      chk($sformatf("rst%0d_busy", k), o_b[k], 0);
      chk($sformatf("rst%0d_timeout", k), o_to[k], 0);
      chk($sformatf("rst%0d_idx", k), o_idx[k], 0);
    end
    model_reset();
    #1 Rst_n = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [7:0] exp_g;   // expected Grant of the MAX_HOLD=16 instance
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic e, logic [7:0] r, logic [7:0] g);
    vec_t v;
    v.en = e; v.req = r; v.exp_g = g;
    tbl.push_back(v);
  endtask

  initial begin
    model_reset();
    // pointer walk and 7->0 wrap, from Ptr=0
    add(1, 8'h84, 8'h04); add(1, 8'h80, 8'h00); add(1, 8'h80, 8'h00);
    add(1, 8'h80, 8'h80); add(1, 8'h84, 8'h80); add(1, 8'h04, 8'h00);
    add(1, 8'h04, 8'h00); add(1, 8'h04, 8'h04); add(1, 8'h00, 8'h00);
    add(1, 8'h00, 8'h00);
    // Req[5] high 3 cycles under MAX_HOLD=16
    add(1, 8'h20, 8'h20); add(1, 8'h20, 8'h20); add(1, 8'h20, 8'h20);
    add(1, 8'h00, 8'h00); add(1, 8'h00, 8'h00); add(1, 8'h00, 8'h00);
    // Enable gating new grants only
    add(0, 8'h10, 8'h00); add(0, 8'h10, 8'h00); add(0, 8'h10, 8'h00);
    add(1, 8'h10, 8'h10); add(0, 8'h10, 8'h10); add(0, 8'h10, 8'h10);
    add(0, 8'h00, 8'h00);

    // power-on reset state
    @(posedge Clk); #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("por%0d_grant", k), o_g[k], 0);
      chk($sformatf("por%0d_busy", k), o_b[k], 0);
      chk($sformatf("por%0d_timeout", k), o_to[k], 0);
      chk($sformatf("por%0d_idx", k), o_idx[k], 0);
    end
    Rst_n = 1'b1;

    // async reset mid-grant, then fresh grant to requester 3
    en = 1'b1; req = 8'h01;
    tick(); chk("t1_grant_pre", o_g[0], 8'h01);
    tick(); chk("t1_grant_hold", o_g[0], 8'h01);
    do_reset();
    req = 8'h08;
    tick();
    chk("t1_grant_after", o_g[0], 8'h08);
    chk("t1_idx_after", o_idx[0], 3);
    req = 8'h00; tick(); tick();

    // table vectors from Ptr=0
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; req = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d_grant", i), o_g[0], tbl[i].exp_g);
      chk($sformatf("tbl%0d_timeout", i), o_to[0], 0);
    end

    // MAX_HOLD=4 with all requesting: 0..7,0, 4 cycles each, pulse, 2 zero cycles
    do_reset();
    en = 1'b1; req = 8'hFF;
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("t2_own%0d_c%0d", o, c), o_g[1], 1 << (o % 8));
        chk($sformatf("t2_own%0d_to%0d", o, c), o_to[1], 0);
      end
      tick();
      chk($sformatf("t2_rev%0d_grant", o), o_g[1], 0);
      chk($sformatf("t2_rev%0d_to", o), o_to[1], 1);
      tick();
      chk($sformatf("t2_gap%0d_grant", o), o_g[1], 0);
      chk($sformatf("t2_gap%0d_to", o), o_to[1], 0);
    end

    // MAX_HOLD=3: Req[1] drops on the expiry edge -> plain release
    do_reset();
    req = 8'h02;
    tick(); tick(); tick();
    chk("t6_grant_cnt3", o_g[2], 8'h02);
    req = 8'h00;
    tick();
    chk("t6_rel_grant", o_g[2], 0);
    chk("t6_rel_to", o_to[2], 0);
    tick(); tick();

    // MAX_HOLD=0: 300 cycles held, never revoked
    do_reset();
    req = 8'h01;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (c % 50 == 49) begin
        chk($sformatf("t6_unl%0d_grant", c), o_g[3], 8'h01);
        chk($sformatf("t6_unl%0d_to", c), o_to[3], 0);
      end
    end
    req = 8'h00; tick(); tick();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) req = 8'($urandom);
      else if ($urandom_range(0, 5) == 0) begin
        int b = $urandom_range(0, 7);
        req[b] = ~req[b];
      end
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
